// File: rtl/keypad_entry_scanner.sv
// 4x4 hex keypad scanner with debounce; accepted digits shift into a 16-bit entry register.
// Optional 2-flop column synchronizer when KEYPAD_COL_SYNC_EN is defined.
module keypad_entry_scanner #(
    parameter int SCAN_TICKS       = 100000,
    parameter int DEBOUNCE_SAMPLES = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  col_in,
    input  logic        clear,
    output logic [3:0]  row_out,
    output logic [15:0] num,
    output logic [3:0]  key_code,
    output logic        key_valid
);
    localparam int              TW        = (SCAN_TICKS > 1) ? $clog2(SCAN_TICKS) : 1;
    localparam logic [TW-1:0]   TICK_LAST = TW'(SCAN_TICKS - 1);
    localparam logic [3:0]      DEB       = 4'(DEBOUNCE_SAMPLES);

    typedef enum logic [1:0] {ST_SCAN, ST_CONFIRM, ST_HELD} state_t;

    state_t        state_q, state_d;
    logic [TW-1:0] tick_q, tick_d;
    logic [1:0]    r_q, r_d;
    logic [1:0]    cand_q, cand_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [15:0]   num_q, num_d;
    logic [3:0]    key_code_q, key_code_d;
    logic          key_valid_q, key_valid_d;

    logic [3:0]    col_s;
    logic          sample, key_seen, accept, advance;
    logic [1:0]    key_col;
    logic [3:0]    mapped;

`ifdef KEYPAD_COL_SYNC_EN
    logic [3:0] sync1_q, sync2_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 4'hF;
            sync2_q <= 4'hF;
        end else begin
            sync1_q <= col_in;
            sync2_q <= sync1_q;
        end
    end
    assign col_s = sync2_q;
`else
    assign col_s = col_in;
`endif

    assign sample = (tick_q == TICK_LAST);

    // A sample is a key only when exactly one column is pulled low.
    always_comb begin
        key_seen = 1'b0;
        key_col  = 2'd0;
        case (col_s)
            4'b1110: begin key_seen = 1'b1; key_col = 2'd0; end
            4'b1101: begin key_seen = 1'b1; key_col = 2'd1; end
            4'b1011: begin key_seen = 1'b1; key_col = 2'd2; end
            4'b0111: begin key_seen = 1'b1; key_col = 2'd3; end
            default: ;
        endcase
    end

    always_comb begin
        mapped = 4'h0;
        case ({r_q, key_col})
            4'h0: mapped = 4'h1;
            4'h1: mapped = 4'h2;
            4'h2: mapped = 4'h3;
            4'h3: mapped = 4'hA;
            4'h4: mapped = 4'h4;
            4'h5: mapped = 4'h5;
            4'h6: mapped = 4'h6;
            4'h7: mapped = 4'hB;
            4'h8: mapped = 4'h7;
            4'h9: mapped = 4'h8;
            4'hA: mapped = 4'h9;
            4'hB: mapped = 4'hC;
            4'hC: mapped = 4'h0;
            4'hD: mapped = 4'hF;
            4'hE: mapped = 4'hE;
            4'hF: mapped = 4'hD;
            default: mapped = 4'h0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_SCAN;
            tick_q      <= '0;
            r_q         <= 2'd0;
            cand_q      <= 2'd0;
            cnt_q       <= 4'd0;
            num_q       <= 16'h0000;
            key_code_q  <= 4'h0;
            key_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            tick_q      <= tick_d;
            r_q         <= r_d;
            cand_q      <= cand_d;
            cnt_q       <= cnt_d;
            num_q       <= num_d;
            key_code_q  <= key_code_d;
            key_valid_q <= key_valid_d;
        end
    end

    // Next state; advance marks the sample points where the row index moves on.
    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        advance = 1'b0;
        if (sample) begin
            case (state_q)
                ST_SCAN: begin
                    if (key_seen) begin
                        if (DEB == 4'd1) begin
                            accept  = 1'b1;
                            state_d = ST_HELD;
                        end else begin
                            state_d = ST_CONFIRM;
                        end
                    end else begin
                        advance = 1'b1;
                    end
                end
                ST_CONFIRM: begin
                    if (key_seen && key_col == cand_q) begin
                        if (cnt_q + 4'd1 == DEB) begin
                            accept  = 1'b1;
                            state_d = ST_HELD;
                        end
                    end else begin
                        advance = 1'b1;
                        state_d = ST_SCAN;
                    end
                end
                ST_HELD: begin
                    if (col_s == 4'hF && cnt_q + 4'd1 == DEB) begin
                        advance = 1'b1;
                        state_d = ST_SCAN;
                    end
                end
                default: state_d = ST_SCAN;
            endcase
        end
    end

    // Datapath: one counter serves as stable count in CONFIRM and release count in HELD.
    always_comb begin
        tick_d      = sample ? '0 : tick_q + TW'(1);
        r_d         = advance ? r_q + 2'd1 : r_q;
        cand_d      = cand_q;
        cnt_d       = cnt_q;
        key_valid_d = accept;
        key_code_d  = accept ? mapped : key_code_q;
        num_d       = accept ? {num_q[11:0], mapped} : num_q;
        if (clear) begin
            num_d = 16'h0000;
        end
        if (sample) begin
            case (state_q)
                ST_SCAN: begin
                    if (key_seen) begin
                        cand_d = key_col;
                        cnt_d  = (state_d == ST_CONFIRM) ? 4'd1 : 4'd0;
                    end
                end
                ST_CONFIRM: cnt_d = (state_d == ST_CONFIRM) ? cnt_q + 4'd1 : 4'd0;
                ST_HELD:    cnt_d = (col_s == 4'hF && state_d == ST_HELD) ? cnt_q + 4'd1 : 4'd0;
                default:    cnt_d = 4'd0;
            endcase
        end
    end

    always_comb begin
        row_out   = ~(4'b0001 << r_q);
        num       = num_q;
        key_code  = key_code_q;
        key_valid = key_valid_q;
    end
endmodule

// File: tb/tb_keypad_entry_scanner.sv
// Self-checking bench for keypad_entry_scanner: a keypad model drives columns from row_out,
// expected codes/entry values come from the key table and nibble-shift arithmetic.
module tb_keypad_entry_scanner;
    localparam int SCAN_TICKS = 8;
    localparam int DEB        = 3;
    localparam int LATENCY    = (DEB - 1) * SCAN_TICKS;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        clear = 1'b0;
    logic [3:0]  col_in;
    logic [3:0]  row_out;
    logic [15:0] num;
    logic [3:0]  key_code;
    logic        key_valid;

    logic [15:0] key_mask = 16'h0000;
    logic [3:0]  key_map [16] = '{4'h1, 4'h2, 4'h3, 4'hA,
                                  4'h4, 4'h5, 4'h6, 4'hB,
                                  4'h7, 4'h8, 4'h9, 4'hC,
                                  4'h0, 4'hF, 4'hE, 4'hD};
    logic [3:0]  exp_q [$];

    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    int   pulse_cnt = 0;
    int   last_pulse_cyc = 0;
    logic [3:0] last_code = 4'h0;
    int   first_low = -1;
    bit   track = 1'b0;

    keypad_entry_scanner #(.SCAN_TICKS(SCAN_TICKS), .DEBOUNCE_SAMPLES(DEB)) dut (
        .clk(clk), .rst_n(rst_n), .col_in(col_in), .clear(clear),
        .row_out(row_out), .num(num), .key_code(key_code), .key_valid(key_valid)
    );

    always #5 clk = ~clk;

    // Keypad: a pressed switch pulls its column low while its row is driven low.
    always_comb begin
        col_in = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (key_mask[r*4+c] && !row_out[r]) col_in[c] = 1'b0;
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    // Sample points fall on edges where the cycle count since reset is a multiple of SCAN_TICKS.
    always @(negedge clk) begin
        if (key_valid) begin
            pulse_cnt      = pulse_cnt + 1;
            last_code      = key_code;
            last_pulse_cyc = cyc;
        end
        if (rst_n && track && first_low < 0 && ((cyc + 1) % SCAN_TICKS) == 0 &&
            $countones(~col_in) == 1)
            first_low = cyc + 1;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
        $fatal(1);
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (3) step();
        rst_n = 1'b1;
    endtask

    task automatic press_key(input logic [3:0] v, input int hold, output bit got);
        int idx;
        int start;
        int waited;
        idx = 0;
        for (int i = 0; i < 16; i++) if (key_map[i] == v) idx = i;
        start    = pulse_cnt;
        key_mask = 16'b1 << idx;
        waited   = 0;
        while (pulse_cnt == start && waited < 120) begin
            step();
            waited++;
        end
        got = (pulse_cnt != start);
        repeat (hold) step();
        key_mask = 16'h0000;
        repeat (40) step();
    endtask

    task automatic test_reset();
        logic [3:0] exp_row;
        do_reset();
        checks++; if (row_out !== 4'b1110) begin errors++; $display("FAIL reset_row: got %b want 1110", row_out); end
        checks++; if (num !== 16'h0000) begin errors++; $display("FAIL reset_num: got %h want 0000", num); end
        checks++; if (key_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", key_valid); end
        checks++; if (key_code !== 4'h0) begin errors++; $display("FAIL reset_code: got %h want 0", key_code); end
        for (int i = 1; i <= 4; i++) begin
            repeat (SCAN_TICKS) step();
            exp_row = ~(4'b0001 << (i % 4));
            checks++;
            if (row_out !== exp_row) begin
                errors++; $display("FAIL idle_rotate_%0d: got %b want %b", i, row_out, exp_row);
            end
        end
    endtask

    task automatic test_single_key();
        int start;
        do_reset();
        start = pulse_cnt;
        first_low = -1;
        track = 1'b1;
        key_mask = 16'b1 << 6;
        repeat (200) step();
        key_mask = 16'h0000;
        repeat (60) step();
        track = 1'b0;
        checks++; if (pulse_cnt - start != 1) begin errors++; $display("FAIL single_pulses: got %0d want 1", pulse_cnt - start); end
        checks++; if (last_code !== 4'h6) begin errors++; $display("FAIL single_code: got %h want 6", last_code); end
        checks++; if (num !== 16'h0006) begin errors++; $display("FAIL single_num: got %h want 0006", num); end
        checks++;
        if (first_low < 0 || last_pulse_cyc - first_low != LATENCY) begin
            errors++; $display("FAIL single_latency: got %0d want %0d", last_pulse_cyc - first_low, LATENCY);
        end
    endtask

    task automatic test_sequence();
        logic [3:0]  seq [5] = '{4'h1, 4'h2, 4'h3, 4'hA, 4'h4};
        logic [15:0] exp_num;
        int start;
        bit got;
        do_reset();
        exp_num = 16'h0000;
        start = pulse_cnt;
        for (int i = 0; i < 5; i++) begin
            press_key(seq[i], 10, got);
            exp_num = {exp_num[11:0], seq[i]};
            checks++;
            if (!got || last_code !== seq[i]) begin
                errors++; $display("FAIL seq_code_%0d: got %h want %h", i, last_code, seq[i]);
            end
        end
        checks++; if (pulse_cnt - start != 5) begin errors++; $display("FAIL seq_pulses: got %0d want 5", pulse_cnt - start); end
        checks++; if (num !== 16'h23A4) begin errors++; $display("FAIL seq_num: got %h want 23a4", num); end
        checks++; if (num !== exp_num) begin errors++; $display("FAIL seq_num_model: got %h want %h", num, exp_num); end
    endtask

    task automatic test_bounce();
        int start;
        do_reset();
        start = pulse_cnt;
        repeat (4) step();
        for (int k = 0; k < 6; k++) begin
            key_mask = (k % 2 == 0) ? (16'b1 << 8) : 16'h0000;
            repeat (SCAN_TICKS) step();
        end
        checks++; if (pulse_cnt != start) begin errors++; $display("FAIL bounce_quiet: got %0d pulses want 0", pulse_cnt - start); end
        first_low = -1;
        track = 1'b1;
        key_mask = 16'b1 << 8;
        repeat (60) step();
        track = 1'b0;
        checks++; if (pulse_cnt - start != 1) begin errors++; $display("FAIL bounce_pulses: got %0d want 1", pulse_cnt - start); end
        checks++; if (last_code !== 4'h7) begin errors++; $display("FAIL bounce_code: got %h want 7", last_code); end
        checks++;
        if (first_low < 0 || last_pulse_cyc - first_low != LATENCY) begin
            errors++; $display("FAIL bounce_latency: got %0d want %0d", last_pulse_cyc - first_low, LATENCY);
        end
        key_mask = 16'h0000;
        repeat (40) step();
    endtask

    task automatic test_multi_key();
        int start;
        do_reset();
        start = pulse_cnt;
        key_mask = 16'b0000_0000_0000_0011;
        repeat (80) step();
        checks++; if (row_out !== 4'b1011) begin errors++; $display("FAIL multi_row_a: got %b want 1011", row_out); end
        repeat (12) step();
        checks++; if (row_out !== 4'b0111) begin errors++; $display("FAIL multi_row_b: got %b want 0111", row_out); end
        checks++; if (pulse_cnt != start) begin errors++; $display("FAIL multi_pulses: got %0d want 0", pulse_cnt - start); end
        key_mask = 16'h0000;
        repeat (20) step();
    endtask

    task automatic test_clear_and_reset();
        logic [3:0] digits [4] = '{4'h1, 4'h2, 4'h3, 4'h4};
        int waited;
        int start;
        bit got;
        do_reset();
        for (int i = 0; i < 4; i++) press_key(digits[i], 5, got);
        checks++; if (num !== 16'h1234) begin errors++; $display("FAIL clear_pre_num: got %h want 1234", num); end
        first_low = -1;
        track = 1'b1;
        key_mask = 16'b1 << 13;
        waited = 0;
        while (first_low < 0 && waited < 80) begin
            step();
            waited++;
        end
        track = 1'b0;
        checks++;
        if (first_low < 0) begin
            errors++; $display("FAIL clear_detect: got no low sample want one within 80 cycles");
        end else begin
            repeat (LATENCY) step();
            clear = 1'b1;
            step();
            clear = 1'b0;
            checks++; if (key_valid !== 1'b1) begin errors++; $display("FAIL clear_valid: got %b want 1", key_valid); end
            checks++; if (key_code !== 4'hF) begin errors++; $display("FAIL clear_code: got %h want f", key_code); end
            checks++; if (num !== 16'h0000) begin errors++; $display("FAIL clear_num: got %h want 0000", num); end
        end
        repeat (20) step();
        do_reset();
        checks++; if (num !== 16'h0000) begin errors++; $display("FAIL held_reset_num: got %h want 0000", num); end
        start = pulse_cnt;
        waited = 0;
        while (pulse_cnt == start && waited < 100) begin
            step();
            waited++;
        end
        checks++; if (pulse_cnt == start) begin errors++; $display("FAIL held_reaccept: got 0 pulses want 1"); end
        checks++; if (last_code !== 4'hF) begin errors++; $display("FAIL held_code: got %h want f", last_code); end
        checks++; if (num !== 16'h000F) begin errors++; $display("FAIL held_num: got %h want 000f", num); end
        key_mask = 16'h0000;
        repeat (40) step();
    endtask

    task automatic test_random();
        logic [15:0] exp_num;
        logic [3:0]  v;
        logic [3:0]  exp_code;
        int start;
        bit got;
        do_reset();
        exp_num = 16'h0000;
        for (int i = 0; i < 6; i++) begin
            v = 4'($urandom_range(0, 15));
            start = pulse_cnt;
            exp_q.push_back(v);
            press_key(v, $urandom_range(0, 30), got);
            exp_code = exp_q.pop_front();
            exp_num = {exp_num[11:0], exp_code};
            checks++; if (pulse_cnt - start != 1) begin errors++; $display("FAIL rand_pulses_%0d: got %0d want 1", i, pulse_cnt - start); end
            checks++; if (last_code !== exp_code) begin errors++; $display("FAIL rand_code_%0d: got %h want %h", i, last_code, exp_code); end
            checks++; if (num !== exp_num) begin errors++; $display("FAIL rand_num_%0d: got %h want %h", i, num, exp_num); end
        end
    endtask

    initial begin
        test_reset();
        test_single_key();
        test_sequence();
        test_bounce();
        test_multi_key();
        test_clear_and_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
